// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: button bit positions,
// repeat FSM state encoding and a small width helper.
package button_conditioner_pkg;

    localparam int NUM_BTN  = 5;

    // Bit positions inside the level/press vectors
    localparam int BTN_MID  = 0;
    localparam int BTN_L    = 1;
    localparam int BTN_R    = 2;
    localparam int BTN_UP   = 3;
    localparam int BTN_DOWN = 4;

    // Auto-repeat state encoding for the up/down buttons
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Larger of two integers, used to size a timer shared by two limits
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button lane: two-flop synchronizer, debounce counter, stable level
// and a one-cycle pulse on every debounced rising edge.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             rise_q;

    // Bring the asynchronous pin into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Flip the stable level only after the input has disagreed long enough;
    // any return to agreement restarts the count
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Registered level copy; comparing against it yields the rise pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            level_q <= stable_q;
            rise_q  <= stable_q & ~level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/button_conditioner.sv
// Turns the five raw board buttons into clean levels and press pulses,
// with auto-repeat on up/down and a long-hold event on mid.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int LONG_CYCLES     = 200000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_mid,
    input  logic       button_l,
    input  logic       button_r,
    input  logic       button_up,
    input  logic       button_down,
    output logic [4:0] level,
    output logic [4:0] press,
    output logic       long_mid
);

    localparam int TIMER_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);
    localparam int LONG_W = $clog2(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_ARM  = LONG_W'(LONG_CYCLES - 2);

    logic [NUM_BTN-1:0] raw_w;
    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] rise_w;
    logic [1:0]         rpt_pulse;
    logic               both_held;
    logic [LONG_W-1:0]  long_cnt_q;
    logic               long_q;

    assign raw_w[BTN_MID]  = button_mid;
    assign raw_w[BTN_L]    = button_l;
    assign raw_w[BTN_R]    = button_r;
    assign raw_w[BTN_UP]   = button_up;
    assign raw_w[BTN_DOWN] = button_down;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_cell
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (raw_w[gi]),
                .level(level_w[gi]),
                .rise (rise_w[gi])
            );
        end
    endgenerate

    // Holding up and down together suppresses auto-repeat on both
    assign both_held = level_w[BTN_UP] & level_w[BTN_DOWN];

    // Lane 0 repeats up, lane 1 repeats down
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rpt
            localparam int IDX = (gi == 0) ? BTN_UP : BTN_DOWN;

            rpt_state_e         state_q;
            rpt_state_e         state_d;
            logic [TIMER_W-1:0] timer_q;
            logic [TIMER_W-1:0] timer_d;
            logic               pulse_w;

            // Repeat state and timer registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= RPT_IDLE;
                    timer_q <= '0;
                end else begin
                    state_q <= state_d;
                    timer_q <= timer_d;
                end
            end

            // Arm on a fresh press, wait out the delay, then pulse periodically;
            // release or a chord drops back to idle and needs a new press
            always_comb begin
                state_d = state_q;
                timer_d = timer_q;
                pulse_w = 1'b0;
                if (!level_w[IDX] || both_held) begin
                    state_d = RPT_IDLE;
                    timer_d = '0;
                end else begin
                    case (state_q)
                        RPT_IDLE: begin
                            if (rise_w[IDX]) begin
                                state_d = RPT_DELAY;
                                timer_d = '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (timer_q == DELAY_LAST) begin
                                pulse_w = 1'b1;
                                timer_d = '0;
                                state_d = RPT_REPEAT;
                            end else begin
                                timer_d = timer_q + TIMER_W'(1);
                            end
                        end
                        RPT_REPEAT: begin
                            if (timer_q == PERIOD_LAST) begin
                                pulse_w = 1'b1;
                                timer_d = '0;
                            end else begin
                                timer_d = timer_q + TIMER_W'(1);
                            end
                        end
                        default: begin
                            state_d = RPT_IDLE;
                            timer_d = '0;
                        end
                    endcase
                end
            end

            assign rpt_pulse[gi] = pulse_w;
        end
    endgenerate

    // Long-hold counter on mid: one pulse on reaching the limit, then saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else if (!level_w[BTN_MID]) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_q <= (long_cnt_q == LONG_ARM);
            if (long_cnt_q != LONG_LAST) begin
                long_cnt_q <= long_cnt_q + LONG_W'(1);
            end
        end
    end

    // Merge repeat pulses into the up/down press bits
    always_comb begin
        press           = rise_w;
        press[BTN_UP]   = rise_w[BTN_UP] | rpt_pulse[0];
        press[BTN_DOWN] = rise_w[BTN_DOWN] | rpt_pulse[1];
    end

    assign level    = level_w;
    assign long_mid = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button
// activity, every cycle compared against a history-based reference model.
module tb_button_conditioner;

    localparam int DC   = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int LC   = 40;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button_mid, button_l, button_r, button_up, button_down;
    logic [4:0] level, press;
    logic       long_mid;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .LONG_CYCLES    (LC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button_mid (button_mid),
        .button_l   (button_l),
        .button_r   (button_r),
        .button_up  (button_up),
        .button_down(button_down),
        .level      (level),
        .press      (press),
        .long_mid   (long_mid)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples and stable levels indexed by clock edge
    // since reset release; edge 0 and before are all zero.
    logic [4:0] raw_h [0:MAXC-1];
    logic [4:0] st_h  [0:MAXC-1];
    int         c;
    int         t0  [2];
    bit         vld [2];
    int         run;
    logic [4:0] exp_level, exp_press;
    logic       exp_long;

    function automatic logic [4:0] raw_at(input int i);
        if (i < 1) return 5'b0;
        return raw_h[i];
    endfunction

    function automatic logic [4:0] st_at(input int i);
        if (i < 1) return 5'b0;
        return st_h[i];
    endfunction

    task automatic model_reset();
        c      = 0;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        t0[0]  = 0;
        t0[1]  = 0;
        run    = 0;
    endtask

    task automatic set_btn(input logic [4:0] v);
        button_mid  = v[0];
        button_l    = v[1];
        button_r    = v[2];
        button_up   = v[3];
        button_down = v[4];
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert (level === 5'b0 && press === 5'b0 && long_mid === 1'b0) else begin
            errors++;
            $error("FAIL %s: observed level=%b press=%b long=%b expected all zero",
                   tag, level, press, long_mid);
        end
    endtask

    // Advance one clock, derive the expected outputs from the rules, compare
    task automatic tick();
        logic [4:0] sp, snew, rw;
        bit         all_diff, both;
        int         bi;
        c++;
        if (c >= MAXC) begin
            $display("FAIL history: cycle index %0d exceeds model capacity %0d", c, MAXC);
            $fatal(1, "model history overflow");
        end
        raw_h[c] = {button_down, button_up, button_r, button_l, button_mid};
        @(posedge clk);
        #1;
        // stable flips once the synchronized input (raw two edges back)
        // has disagreed with it for DC consecutive edges
        sp = st_at(c - 1);
        for (int b = 0; b < 5; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DC; k++) begin
                rw = raw_at(c - 2 - k);
                if (rw[b] == sp[b]) all_diff = 1'b0;
            end
            snew[b] = all_diff ? ~sp[b] : sp[b];
        end
        st_h[c]   = snew;
        exp_level = sp;
        exp_press = sp & ~st_at(c - 2);
        both      = sp[3] & sp[4];
        for (int j = 0; j < 2; j++) begin
            bi = (j == 0) ? 3 : 4;
            if (exp_press[bi]) begin
                t0[j]  = c;
                vld[j] = 1'b1;
            end
            if (!sp[bi] || both) vld[j] = 1'b0;
            if (vld[j] && (c - t0[j]) >= RD && ((c - t0[j] - RD) % RP) == 0)
                exp_press[bi] = 1'b1;
        end
        exp_long = (run == LC - 1);
        run      = sp[0] ? run + 1 : 0;

        checks++;
        assert (level === exp_level) else begin
            errors++;
            $error("FAIL level c=%0d: observed %b expected %b", c, level, exp_level);
        end
        checks++;
        assert (press === exp_press) else begin
            errors++;
            $error("FAIL press c=%0d: observed %b expected %b", c, press, exp_press);
        end
        checks++;
        assert (long_mid === exp_long) else begin
            errors++;
            $error("FAIL long_mid c=%0d: observed %b expected %b", c, long_mid, exp_long);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset in the middle of a cycle, held across a few edges
    task automatic mid_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero("in_reset");
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    int         seg [5];
    logic [4:0] rval;

    initial begin
        rst_n = 1'b0;
        set_btn(5'b0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero("reset");
        end
        rst_n = 1'b1;
        $display("step: reset released");

        // clean press and release of l
        ticks(10);
        button_l = 1'b1; ticks(15);
        button_l = 1'b0; ticks(15);
        $display("step: clean press on l done, checks=%0d", checks);

        // bouncing r, then a clean hold
        for (int i = 0; i < 10; i++) begin
            button_r = (i % 2 == 0);
            ticks(2);
        end
        button_r = 1'b1; ticks(15);
        button_r = 1'b0; ticks(15);
        $display("step: bounce on r done, checks=%0d", checks);

        // auto-repeat on up
        button_up = 1'b1; ticks(67);
        button_up = 1'b0; ticks(25);
        $display("step: auto-repeat on up done, checks=%0d", checks);

        // up and down together
        button_up = 1'b1;   ticks(5);
        button_down = 1'b1; ticks(50);
        button_down = 1'b0; ticks(40);
        button_up = 1'b0;   ticks(15);
        $display("step: up+down chord done, checks=%0d", checks);

        // long hold of mid
        button_mid = 1'b1; ticks(60);
        button_mid = 1'b0; ticks(15);
        $display("step: long mid done, checks=%0d", checks);

        // random segments: mostly short glitches, some long holds
        for (int b = 0; b < 5; b++) seg[b] = 0;
        rval = 5'b0;
        for (int i = 0; i < 700; i++) begin
            for (int b = 0; b < 5; b++) begin
                if (seg[b] == 0) begin
                    rval[b] = 1'($urandom_range(0, 1));
                    seg[b]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 70))
                                                           : int'($urandom_range(1, 6));
                end
                seg[b]--;
            end
            set_btn(rval);
            tick();
        end
        set_btn(5'b0); ticks(20);
        $display("step: random activity done, checks=%0d", checks);

        // reset while down is auto-repeating, button held through release
        button_down = 1'b1; ticks(40);
        mid_reset();
        ticks(45);
        button_down = 1'b0; ticks(15);
        $display("step: reset during repeat done, checks=%0d", checks);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
